// File: rtl/rs_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : rs_encoder
//  Purpose  : Systematic Reed-Solomon encoder over GF(2^8) (poly 0x11D, b0 = 0),
//             streaming valid/ready in and out. Optional macro
//             RS_ENC_SHORTENED_EN adds in_last for shortened codewords.
//  Revision : 1.0 - initial release
// ============================================================================
module rs_encoder #(
    parameter int CORRECTION_CAPACITY = 8,
    parameter int NB_SYMBOL_BITS      = 8,
    parameter int BLOCK_LENGTH        = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NB_SYMBOL_BITS-1:0] in_data,
    input  logic                      in_valid,
`ifdef RS_ENC_SHORTENED_EN
    input  logic                      in_last,
`endif
    output logic                      in_ready,
    output logic [NB_SYMBOL_BITS-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_sop,
    output logic                      out_eop
);

    localparam int c_m      = NB_SYMBOL_BITS;
    localparam int c_npar   = 2 * CORRECTION_CAPACITY;
    localparam int c_k      = BLOCK_LENGTH - c_npar;
    localparam int c_dcnt_w = $clog2(c_k);
    localparam int c_pcnt_w = $clog2(c_npar);

    localparam logic [c_m-1:0]      c_prim_low  = c_m'(8'h1D);
    localparam logic [c_dcnt_w-1:0] c_dcnt_last = c_dcnt_w'(c_k - 1);
    localparam logic [c_pcnt_w-1:0] c_pcnt_last = c_pcnt_w'(c_npar - 1);

    // Shift-and-add multiply, reducing by the primitive polynomial each step
    function automatic logic [c_m-1:0] gf_mul(input logic [c_m-1:0] a,
                                              input logic [c_m-1:0] b);
        logic [c_m-1:0] p;
        p = '0;
        for (int i = c_m - 1; i >= 0; i--) begin
            p = {p[c_m-2:0], 1'b0} ^ (p[c_m-1] ? c_prim_low : '0);
            if (b[i]) p = p ^ a;
        end
        return p;
    endfunction

    // g(x) = prod (x + alpha^i), i = 0..2t-1; monic top coefficient dropped
    function automatic logic [c_npar*c_m-1:0] gen_poly();
        logic [c_m-1:0]        g [0:c_npar];
        logic [c_m-1:0]        root;
        logic [c_npar*c_m-1:0] res;
        g[0] = c_m'(1);
        for (int j = 1; j <= c_npar; j++) g[j] = '0;
        root = c_m'(1);
        for (int i = 0; i < c_npar; i++) begin
            for (int j = c_npar; j >= 1; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
            g[0] = gf_mul(g[0], root);
            root = gf_mul(root, c_m'(2));
        end
        res = '0;
        for (int j = 0; j < c_npar; j++) res[j*c_m +: c_m] = g[j];
        return res;
    endfunction

    localparam logic [c_npar*c_m-1:0] c_gen = gen_poly();

    typedef enum logic [0:0] {
        ST_DATA   = 1'b0,
        ST_PARITY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [c_dcnt_w-1:0]   r_dcnt;
    logic [c_pcnt_w-1:0]   r_pcnt;
    logic [c_m-1:0]        r_b    [0:c_npar-1];
    logic [c_m-1:0]        w_prod [0:c_npar-1];
    logic [c_m-1:0]        w_fb;
    logic                  w_slot_free;
    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_par_load;
    logic                  w_last_data;
    logic                  w_last_par;
    logic                  w_last_in;
    logic                  w_end_msg;

`ifdef RS_ENC_SHORTENED_EN
    assign w_last_in = in_last;
`else
    assign w_last_in = 1'b0;
`endif

    assign w_slot_free = !out_valid || out_ready;
    assign w_last_data = (r_dcnt == c_dcnt_last);
    assign w_last_par  = (r_pcnt == c_pcnt_last);
    assign w_end_msg   = w_last_data || w_last_in;
    assign w_fb        = in_data ^ r_b[c_npar-1];
    assign in_ready    = w_in_ready;

    for (genvar j = 0; j < c_npar; j++) begin : g_mul
        assign w_prod[j] = gf_mul(c_gen[j*c_m +: c_m], w_fb);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_DATA;
        else     r_state <= w_state_next;
    end

    // rst gates in_ready so nothing is offered as accepted while held in reset
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_accept     = 1'b0;
        w_par_load   = 1'b0;
        case (r_state)
            ST_DATA: begin
                w_in_ready = w_slot_free && !rst;
                w_accept   = in_valid && w_in_ready;
                if (w_accept && w_end_msg) w_state_next = ST_PARITY;
            end
            ST_PARITY: begin
                w_par_load = w_slot_free;
                if (w_par_load && w_last_par) w_state_next = ST_DATA;
            end
            default: w_state_next = ST_DATA;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dcnt    <= '0;
            r_pcnt    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            for (int j = 0; j < c_npar; j++) r_b[j] <= '0;
        end else if (w_accept) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            out_sop   <= (r_dcnt == '0);
            out_eop   <= 1'b0;
            r_b[0]    <= w_prod[0];
            for (int j = 1; j < c_npar; j++) r_b[j] <= r_b[j-1] ^ w_prod[j];
            r_dcnt    <= w_end_msg ? '0 : r_dcnt + 1'b1;
        end else if (w_par_load) begin
            // Shifting zeros in leaves the register clear for the next block
            out_data  <= r_b[c_npar-1];
            out_valid <= 1'b1;
            out_sop   <= 1'b0;
            out_eop   <= w_last_par;
            r_b[0]    <= '0;
            for (int j = 1; j < c_npar; j++) r_b[j] <= r_b[j-1];
            r_pcnt    <= w_last_par ? '0 : r_pcnt + 1'b1;
        end else if (w_slot_free) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rs_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rs_encoder
//  Purpose  : Randomized self-checking bench for rs_encoder against a
//             polynomial long-division model built on log/antilog tables.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rs_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
`ifdef RS_ENC_SHORTENED_EN
    logic       in_last = 1'b0;
`endif
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_sop;
    logic       out_eop;

    rs_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
`ifdef RS_ENC_SHORTENED_EN
        .in_last   (in_last),
`endif
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sop   (out_sop),
        .out_eop   (out_eop)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         ready_mode = 0;
    int         gexp [0:255];
    int         glog [0:255];
    int         gm   [0:16];
    logic [9:0] out_q[$];
    int         out_t[$];
    logic [9:0] exp_q[$];
    logic [8:0] stim[$];
    logic [7:0] msg[$];
    logic [7:0] keep_msg[$];
    int         hold_bad = 0;
    int         stall_seen = 0;
    logic       prev_stall = 1'b0;
    logic [10:0] prev_out = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (ready_mode == 1) out_ready = ~out_ready;
        else                 out_ready = 1'b1;
    end

    // Output monitor: a handshake seen at the falling edge completes at the next rising edge
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                stall_seen <= stall_seen + 1;
                if ({out_valid, out_eop, out_sop, out_data} !== prev_out) hold_bad <= hold_bad + 1;
            end
            if (out_valid && out_ready) begin
                out_q.push_back({out_eop, out_sop, out_data});
                out_t.push_back(cyc);
            end
            prev_stall <= out_valid && !out_ready;
            prev_out   <= {out_valid, out_eop, out_sop, out_data};
        end else begin
            prev_stall <= 1'b0;
        end
    end

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gexp[(glog[a] + glog[b]) % 255];
    endfunction

    task automatic build_tables();
        int v;
        gexp[0] = 1;
        for (int i = 1; i < 255; i++) begin
            v = gexp[i-1] << 1;
            if (v >= 256) v = v ^ 285;
            gexp[i] = v;
        end
        gexp[255] = 1;
        glog[0] = 0;
        for (int i = 0; i < 255; i++) glog[gexp[i]] = i;
        gm[0] = 1;
        for (int j = 1; j <= 16; j++) gm[j] = 0;
        for (int i = 0; i < 16; i++) begin
            for (int j = 16; j >= 1; j--) gm[j] = gm[j-1] ^ gmul(gm[j], gexp[i]);
            gm[0] = gmul(gm[0], gexp[i]);
        end
    endtask

    // Codeword = message followed by remainder of (zero-padded message * x^16) / g(x)
    task automatic model_append();
        int r [0:254];
        int len;
        int pad;
        int coef;
        len = msg.size();
        pad = 239 - len;
        for (int i = 0; i < 255; i++) r[i] = 0;
        for (int i = 0; i < len; i++) r[pad+i] = int'(msg[i]);
        for (int i = 0; i < 239; i++) begin
            coef = r[i];
            if (coef != 0)
                for (int j = 1; j <= 16; j++) r[i+j] = r[i+j] ^ gmul(coef, gm[16-j]);
        end
        for (int i = 0; i < len; i++) exp_q.push_back({1'b0, (i == 0), msg[i]});
        for (int k = 0; k < 16; k++) exp_q.push_back({(k == 15), 1'b0, 8'(r[239+k])});
    endtask

    task automatic load_msg();
        for (int i = 0; i < msg.size(); i++) stim.push_back({(i == msg.size() - 1), msg[i]});
    endtask

    task automatic clear_all();
        out_q.delete(); out_t.delete(); exp_q.delete(); stim.delete(); msg.delete();
    endtask

    task automatic drive(input int count, input bit gaps);
        int  waitc;
        bit  done;
        for (int i = 0; i < count; i++) begin
            waitc = 0;
            done  = 1'b0;
            while (!done) begin
                @(posedge clk); #1;
                in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                in_data  = in_valid ? stim[i][7:0] : 8'($urandom);
`ifdef RS_ENC_SHORTENED_EN
                in_last  = in_valid ? stim[i][8] : 1'b0;
`endif
                @(negedge clk);
                if (in_valid && in_ready) done = 1'b1;
                else begin
                    waitc++;
                    if (waitc > 300) begin
                        n_vec++; n_err++;
                        $display("FAIL input_timeout: symbol %0d never accepted, wanted acceptance within 300 cycles", i);
                        in_valid = 1'b0;
                        return;
                    end
                end
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
`ifdef RS_ENC_SHORTENED_EN
        in_last  = 1'b0;
`endif
    endtask

    task automatic wait_out(input int n);
        int c;
        c = 0;
        while (out_q.size() < n && c < 3000) begin
            @(negedge clk);
            c++;
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_vec++;
        if ({in_ready, out_valid, out_sop, out_eop, out_data} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy/vld/sop/eop/data %h, expected 000", {in_ready, out_valid, out_sop, out_eop, out_data});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: got %b, expected 1", in_ready);
        end
    endtask

    task automatic test_zero_block();
        int lowc;
        clear_all();
        ready_mode = 0;
        for (int i = 0; i < 239; i++) msg.push_back(8'h00);
        load_msg();
        model_append();
        drive(239, 1'b0);
        lowc = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (in_ready) break;
            lowc++;
        end
        wait_out(255);
        n_vec++;
        if (lowc !== 16) begin n_err++; $display("FAIL zero_ready_low: got %0d cycles, expected 16", lowc); end
        n_vec++;
        if (out_q.size() !== exp_q.size()) begin n_err++; $display("FAIL zero_len: got %0d, expected %0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            n_vec++;
            if (out_q[i] !== exp_q[i]) begin n_err++; $display("FAIL zero_sym[%0d]: got %h, expected %h", i, out_q[i], exp_q[i]); end
        end
        if (out_t.size() == 255) begin
            n_vec++;
            if (out_t[254] - out_t[0] !== 254) begin n_err++; $display("FAIL zero_throughput: got span %0d, expected 254", out_t[254] - out_t[0]); end
        end
    endtask

    task automatic test_generator();
        clear_all();
        for (int i = 0; i < 238; i++) msg.push_back(8'h00);
        msg.push_back(8'h01);
        load_msg();
        model_append();
        drive(239, 1'b0);
        wait_out(255);
        n_vec++;
        if (out_q.size() !== 255) begin n_err++; $display("FAIL gen_len: got %0d, expected 255", out_q.size()); end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            n_vec++;
            if (out_q[i] !== exp_q[i]) begin n_err++; $display("FAIL gen_sym[%0d]: got %h, expected %h", i, out_q[i], exp_q[i]); end
        end
        if (out_q.size() == 255) begin
            for (int k = 0; k < 16; k++) begin
                n_vec++;
                if (out_q[239+k][7:0] !== 8'(gm[15-k])) begin
                    n_err++; $display("FAIL gen_coef[%0d]: got %h, expected %h", 15 - k, out_q[239+k][7:0], 8'(gm[15-k]));
                end
            end
            n_vec++;
            if (out_q[254][7:0] !== 8'(gexp[120])) begin n_err++; $display("FAIL gen_g0: got %h, expected %h", out_q[254][7:0], 8'(gexp[120])); end
        end
    endtask

    task automatic test_random();
        int s;
        int bad_syn;
        clear_all();
        for (int i = 0; i < 239; i++) msg.push_back(8'($urandom));
        keep_msg = msg;
        load_msg();
        model_append();
        drive(239, 1'b0);
        wait_out(255);
        n_vec++;
        if (out_q.size() !== exp_q.size()) begin n_err++; $display("FAIL rand_len: got %0d, expected %0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            n_vec++;
            if (out_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_sym[%0d]: got %h, expected %h", i, out_q[i], exp_q[i]); end
        end
        // A valid codeword evaluates to zero at every generator root
        bad_syn = 0;
        for (int k = 0; k < 16; k++) begin
            s = 0;
            for (int i = 0; i < out_q.size(); i++) s = gmul(s, gexp[k]) ^ int'(out_q[i][7:0]);
            if (s != 0) bad_syn++;
        end
        n_vec++;
        if (bad_syn !== 0) begin n_err++; $display("FAIL rand_syndrome: got %0d nonzero syndromes, expected 0", bad_syn); end
    endtask

    task automatic test_backpressure();
        clear_all();
        msg = keep_msg;
        load_msg();
        model_append();
        ready_mode = 1;
        drive(239, 1'b1);
        wait_out(255);
        ready_mode = 0;
        repeat (4) @(negedge clk);
        n_vec++;
        if (out_q.size() !== exp_q.size()) begin n_err++; $display("FAIL bp_len: got %0d, expected %0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            n_vec++;
            if (out_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_sym[%0d]: got %h, expected %h", i, out_q[i], exp_q[i]); end
        end
        n_vec++;
        if (hold_bad !== 0) begin n_err++; $display("FAIL bp_hold: got %0d unstable stalls, expected 0", hold_bad); end
        n_vec++;
        if (stall_seen < 1) begin n_err++; $display("FAIL bp_stalls: got %0d stalls, expected at least 1", stall_seen); end
    endtask

    task automatic test_back_to_back();
        clear_all();
        for (int i = 0; i < 239; i++) msg.push_back(8'($urandom));
        load_msg();
        model_append();
        msg.delete();
        for (int i = 0; i < 239; i++) msg.push_back(8'($urandom));
        load_msg();
        model_append();
        drive(478, 1'b0);
        wait_out(510);
        n_vec++;
        if (out_q.size() !== exp_q.size()) begin n_err++; $display("FAIL b2b_len: got %0d, expected %0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            n_vec++;
            if (out_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_sym[%0d]: got %h, expected %h", i, out_q[i], exp_q[i]); end
        end
        if (out_t.size() == 510) begin
            n_vec++;
            if (out_t[509] - out_t[0] !== 509) begin n_err++; $display("FAIL b2b_throughput: got span %0d, expected 509", out_t[509] - out_t[0]); end
        end
    endtask

    task automatic test_mid_reset();
        clear_all();
        for (int i = 0; i < 239; i++) msg.push_back(8'($urandom));
        load_msg();
        drive(100, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({in_ready, out_valid, out_sop, out_eop, out_data} !== 12'h000) begin
            n_err++;
            $display("FAIL midrst_outputs: got rdy/vld/sop/eop/data %h, expected 000", {in_ready, out_valid, out_sop, out_eop, out_data});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_all();
        for (int i = 1; i <= 239; i++) msg.push_back(8'(i));
        load_msg();
        model_append();
        drive(239, 1'b0);
        wait_out(255);
        n_vec++;
        if (out_q.size() !== exp_q.size()) begin n_err++; $display("FAIL midrst_len: got %0d, expected %0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            n_vec++;
            if (out_q[i] !== exp_q[i]) begin n_err++; $display("FAIL midrst_sym[%0d]: got %h, expected %h", i, out_q[i], exp_q[i]); end
        end
    endtask

`ifdef RS_ENC_SHORTENED_EN
    task automatic test_shortened();
        clear_all();
        for (int i = 0; i < 10; i++) msg.push_back(8'($urandom));
        load_msg();
        model_append();
        drive(10, 1'b0);
        wait_out(26);
        n_vec++;
        if (out_q.size() !== 26) begin n_err++; $display("FAIL short_len: got %0d, expected 26", out_q.size()); end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            n_vec++;
            if (out_q[i] !== exp_q[i]) begin n_err++; $display("FAIL short_sym[%0d]: got %h, expected %h", i, out_q[i], exp_q[i]); end
        end
    endtask
`endif

    initial begin
        build_tables();
        test_reset();
        test_zero_block();
        test_generator();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
`ifdef RS_ENC_SHORTENED_EN
        test_shortened();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
